// File: rtl/clock_group_reset_sequencer_if.sv
// Interface: groups the reset-request input and the sequencing outputs of
// clock_group_reset_sequencer.
//   req_reset     : active-high, level-sensitive reset request (watchdog/sw)
//   member_reset  : per-member active-high reset, one bit per member
//   busy          : high while any member_reset bit is high
//   done          : one-cycle pulse when the last member is released
//   cause         : last reset source, 0 = system reset, 1 = req_reset
//   req_count     : saturating count of accepted reset requests
// Modports: master = requester/consumer side, slave = sequencer side.
interface clock_group_reset_sequencer_if #(
    parameter int unsigned NUM_MEMBERS = 3
);
    logic                   req_reset;
    logic [NUM_MEMBERS-1:0] member_reset;
    logic                   busy;
    logic                   done;
    logic                   cause;
    logic [7:0]             req_count;

    modport master (
        output req_reset,
        input  member_reset, busy, done, cause, req_count
    );

    modport slave (
        input  req_reset,
        output member_reset, busy, done, cause, req_count
    );
endinterface

// File: rtl/clock_group_reset_sequencer.sv
// Per-member reset sequencer for the peripheral-bus clock group.
// Holds every member in reset while hold = !reset || req_reset, keeps them
// there for STRETCH_CYCLES edges after hold clears, then releases member 0,
// 1, ... one every STAGGER_CYCLES edges. Reports busy/done and reset cause.
// Ports:
//   clock : single clock for all logic
//   reset : synchronous, active-low system reset
//   bus   : slave side of clock_group_reset_sequencer_if (req_reset in,
//           member_reset/busy/done/cause/req_count out, all registered)
module clock_group_reset_sequencer #(
    parameter int unsigned NUM_MEMBERS    = 3,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    clock_group_reset_sequencer_if.slave bus
);
    localparam int unsigned CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ?
                                      STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;

    // Counter value seen on the edge that performs a release: the counter
    // starts at 0 on the edge after E0 (or after a release).
    localparam logic [CNT_W-1:0]       STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(NUM_MEMBERS - 1);
    localparam logic [NUM_MEMBERS-1:0] ONE          = NUM_MEMBERS'(1);

    typedef enum logic [1:0] {
        HOLD,
        STRETCH,
        RELEASE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_MEMBERS-1:0] mr_q, mr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cause_q, cause_d;
    logic [7:0]             req_count_q, req_count_d;
    logic                   req_prev_q, req_prev_d;
    logic                   hold;
    logic                   release_now;

    assign hold = !reset || bus.req_reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            mr_q        <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cause_q     <= 1'b0;
            req_count_q <= '0;
            req_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mr_q        <= mr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            req_count_q <= req_count_d;
            req_prev_q  <= req_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mr_d        = mr_q;
        done_d      = 1'b0;
        release_now = 1'b0;

        // hold takes priority over any release due on the same edge
        if (hold) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            mr_d    = '1;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_LAST) release_now = 1'b1;
                    else                       cnt_d = cnt_q + 1'b1;
                end
                RELEASE: begin
                    if (cnt_q == STAGGER_LAST) release_now = 1'b1;
                    else                       cnt_d = cnt_q + 1'b1;
                end
                RUN: begin
                end
                default: state_d = HOLD;
            endcase

            // With one member the first release is also the last, so the
            // block goes straight from STRETCH to RUN.
            if (release_now) begin
                mr_d  = mr_q & ~(ONE << idx_q);
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RELEASE;
                    idx_d   = idx_q + 1'b1;
                end
            end
        end

        busy_d = |mr_d;
    end

    // Rising edge of req_reset is one accepted request, however long it stays high.
    always_comb begin
        cause_d     = cause_q;
        req_count_d = req_count_q;
        req_prev_d  = bus.req_reset;
        if (bus.req_reset && !req_prev_q) begin
            cause_d = 1'b1;
            if (req_count_q != 8'hFF) req_count_d = req_count_q + 1'b1;
        end
    end

    assign bus.member_reset = mr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cause        = cause_q;
    assign bus.req_count    = req_count_q;
endmodule
